vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the MonacoGP display path; sits directly upstream of the colour mapper.
//  Divides Clk into a pixel-rate enable and runs horizontal/vertical counters.
//  Drives DrawX/DrawY to the colour mapper for track/car lookup.
//  Emits hs/vs/blank_n delayed by PIPE_DLY pixels so they align with the mapper's registered RGB.
// PARAMETERS
//  CLK_DIV   2    Clk cycles per pixel (50 MHz -> 25 MHz); >=1
//  H_VISIBLE 640  active pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_BP      48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_VISIBLE 480  active lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_BP      33   vertical back porch, lines (V_TOTAL = 525)
//  PIPE_DLY  1    pixel ticks of delay applied to hs/vs/blank_n; 0..4
// PORTS
//  Clk          in   1   system clock; all state changes on rising edge
//  Reset_n      in   1   asynchronous active-low reset
//  pixel_en     out  1   one-Clk pulse per pixel; marks the cycle in which the counters advance
//  DrawX        out  10  current pixel column (h_cnt), undelayed
//  DrawY        out  10  current line (v_cnt), undelayed
//  hs           out  1   horizontal sync, active low, delayed PIPE_DLY ticks
//  vs           out  1   vertical sync, active low, delayed PIPE_DLY ticks
//  blank_n      out  1   1 = visible pixel, delayed PIPE_DLY ticks
//  line_start   out  1   one-Clk pulse: pixel_en & (h_cnt==0)
//  frame_start  out  1   one-Clk pulse: pixel_en & (h_cnt==0) & (v_cnt==0)
// BEHAVIOUR
//  Reset (async, Reset_n=0): div_cnt=0, h_cnt=0, v_cnt=0, pixel_en=0, hs=1, vs=1.
//   - Reset also clears every delay-line stage to the inactive state (hs=1, vs=1, blank_n=0).
//   - blank_n reset value is 0 when PIPE_DLY>0; it is 1 when PIPE_DLY==0, because it is decoded from (0,0).
//   - Reset asserted mid-frame forces these values immediately, with no clock edge required.
//  Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
//   - pixel_en = (div_cnt==CLK_DIV-1), decoded from the register.
//   - With CLK_DIV=1, pixel_en=1 in every cycle after reset.
//  Counters advance only on Clk edges where pixel_en=1:
//   - h_cnt==H_TOTAL-1 -> h_cnt=0 and v_cnt increments; otherwise h_cnt+1.
//   - v_cnt==V_TOTAL-1 at an h wrap -> v_cnt=0.
//   - No other wrap exists; the counter values never exceed TOTAL-1.
//  Raw decode from the current counters:
//   - hs_r = ~(h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1])
//   - vs_r = ~(v_cnt in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1])
//   - vis  = (h_cnt<H_VISIBLE) & (v_cnt<V_VISIBLE)
//  Delay line: a PIPE_DLY-stage shift register of {hs_r, vs_r, vis}.
//   - It shifts only on pixel_en and holds otherwise.
//   - Outputs hs/vs/blank_n equal the decode of the counters PIPE_DLY ticks earlier.
//   - PIPE_DLY==0: outputs are the raw decode directly.
//  First pixel_en after reset release occurs in Clk cycle CLK_DIV-1.
//   - h_cnt=0 and v_cnt=0 in that cycle, so frame_start and line_start both fire.
//  DrawX/DrawY change only in the cycle after a pixel_en and are stable for CLK_DIV cycles.
//  No input handshake; the block free-runs. A frame is exactly H_TOTAL*V_TOTAL*CLK_DIV Clk cycles.
// TESTING
//  1. Release reset, defaults
//     -> pixel_en in cycles 1,3,5,...; frame_start and line_start high in cycle 1 only.
//     -> DrawX=1 in cycle 2.
//  2. Run one line, defaults
//     -> hs low for exactly 96 pixel ticks, starting at the decode of h_cnt=656 delayed 1 tick.
//     -> line_start period = 1600 Clk.
//  3. Run one frame, defaults
//     -> vs low on lines 490-491 (1600 Clk x 2 = 3200 Clk low).
//     -> frame_start period = 840000 Clk.
//     -> DrawY wraps 524 -> 0.
//  4. PIPE_DLY=1
//     -> blank_n falls on the tick after DrawX=640 is presented and rises on the tick after DrawX=0.
//     -> blank_n stays 0 for all of lines 480-524.
//  5. Reset mid-line: drop Reset_n asynchronously at DrawX=300, DrawY=100
//     -> same Clk phase: DrawX=0, DrawY=0, hs=1, vs=1, blank_n=0.
//     -> after release, sequence restarts as in test 1.
//  6. CLK_DIV=1, PIPE_DLY=0
//     -> pixel_en constant 1 after reset; blank_n=1 during reset.
//     -> hs low exactly while DrawX in 656..751.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing source: divides Clk down to a pixel enable, runs the h/v counters and
// emits hs/vs/blank_n through a short delay line so they line up with registered pixel data.
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int PIPE_DLY  = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       pixel_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank_n,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             hs_r;
    logic             vs_r;
    logic             vis;
    logic [2:0]       raw;

    // Divider stage: pixel_en is masked by reset so it reads 0 in reset even when CLK_DIV==1
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    assign pixel_en = Reset_n & (div_cnt == DIV_LAST);

    // Raster counter stage
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign DrawX       = h_cnt;
    assign DrawY       = v_cnt;
    assign line_start  = pixel_en & (h_cnt == 10'd0);
    assign frame_start = line_start & (v_cnt == 10'd0);

    assign hs_r = ~((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vs_r = ~((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    assign vis  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign raw  = {hs_r, vs_r, vis};

    // Sync delay stage: shifts once per pixel, resets to the inactive pattern
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign {hs, vs, blank_n} = raw;
        end else begin : g_dly
            logic [2:0] sync_p [PIPE_DLY];

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    for (int i = 0; i < PIPE_DLY; i++)
                        sync_p[i] <= 3'b110;
                end else if (pixel_en) begin
                    sync_p[0] <= raw;
                    for (int i = 1; i < PIPE_DLY; i++)
                        sync_p[i] <= sync_p[i-1];
                end
            end

            assign {hs, vs, blank_n} = sync_p[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, a shrunken raster, and a
// divide-by-1 / no-delay build) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    always #5 Clk = ~Clk;

    logic       pe_d, ls_d, fs_d, hs_d, vs_d, bl_d;
    logic [9:0] x_d, y_d;
    logic       pe_s, ls_s, fs_s, hs_s, vs_s, bl_s;
    logic [9:0] x_s, y_s;
    logic       pe_f, ls_f, fs_f, hs_f, vs_f, bl_f;
    logic [9:0] x_f, y_f;

    vga_timing_gen u_def (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pe_d), .DrawX(x_d), .DrawY(y_d),
        .hs(hs_d), .vs(vs_d), .blank_n(bl_d), .line_start(ls_d), .frame_start(fs_d)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(2)
    ) u_small (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pe_s), .DrawX(x_s), .DrawY(y_s),
        .hs(hs_s), .vs(vs_s), .blank_n(bl_s), .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(0)) u_fast (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pe_f), .DrawX(x_f), .DrawY(y_f),
        .hs(hs_f), .vs(vs_f), .blank_n(bl_f), .line_start(ls_f), .frame_start(fs_f)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;

    logic [31:0] q_def[$];
    logic [31:0] q_sm[$];
    logic [31:0] q_fast[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, obs, exp, t);
    endtask

    function automatic logic [31:0] pack(input logic pe, ls, fs, hs, vs, bl,
                                         input logic [9:0] y, x);
        return {6'd0, pe, ls, fs, hs, vs, bl, y, x};
    endfunction

    // Expected outputs t cycles after reset release, derived from absolute pixel count
    function automatic logic [31:0] model(input int tt, input int cdiv,
                                          input int hv, hfp, hsw, hbp,
                                          input int vv, vfp, vsw, vbp,
                                          input int dly, input bit in_rst);
        int  ht, vt, n, h, v, m, hd, vd;
        bit  pe, ls, fs, hso, vso, blo;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        if (in_rst)
            return pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, (dly == 0), 10'd0, 10'd0);
        n  = tt / cdiv;
        pe = ((tt % cdiv) == cdiv - 1);
        h  = n % ht;
        v  = (n / ht) % vt;
        ls = pe && (h == 0);
        fs = ls && (v == 0);
        if (n >= dly) begin
            m   = n - dly;
            hd  = m % ht;
            vd  = (m / ht) % vt;
            hso = !((hd >= hv + hfp) && (hd < hv + hfp + hsw));
            vso = !((vd >= vv + vfp) && (vd < vv + vfp + vsw));
            blo = (hd < hv) && (vd < vv);
        end else begin
            hso = 1'b1;
            vso = 1'b1;
            blo = 1'b0;
        end
        return pack(pe, ls, fs, hso, vso, blo, 10'(v), 10'(h));
    endfunction

    task automatic push_all(input bit in_rst);
        q_def.push_back(model(t, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1, in_rst));
        q_sm.push_back(model(t, 3, 16, 2, 3, 3, 6, 1, 2, 1, 2, in_rst));
        q_fast.push_back(model(t, 1, 640, 16, 96, 48, 480, 10, 2, 33, 0, in_rst));
    endtask

    task automatic compare_all();
        chk("sb_def",  pack(pe_d, ls_d, fs_d, hs_d, vs_d, bl_d, y_d, x_d), q_def.pop_front());
        chk("sb_small", pack(pe_s, ls_s, fs_s, hs_s, vs_s, bl_s, y_s, x_s), q_sm.pop_front());
        chk("sb_fast", pack(pe_f, ls_f, fs_f, hs_f, vs_f, bl_f, y_f, x_f), q_fast.pop_front());
    endtask

    bit prev_hs_d, prev_bl_d, prev_vs_s;
    int hs_low_d, vs_low_s, last_ls_d, last_fs_s;
    logic [9:0] prev_y_s;

    task automatic monitor_init();
        prev_hs_d = 1'b1;
        prev_bl_d = 1'b0;
        prev_vs_s = 1'b1;
        hs_low_d  = 0;
        vs_low_s  = 0;
        last_ls_d = -1;
        last_fs_s = -1;
        prev_y_s  = 10'd0;
    endtask

    // Interval and edge-position measurements on top of the per-cycle scoreboard
    task automatic monitor();
        if (!hs_d && prev_hs_d) begin
            chk("hs_fall_drawx", x_d, 10'd657);
            hs_low_d = 0;
        end
        if (!hs_d) hs_low_d++;
        if (hs_d && !prev_hs_d) chk("hs_low_clks", hs_low_d, 192);
        prev_hs_d = hs_d;

        if (!bl_d && prev_bl_d) chk("blank_fall_drawx", x_d, 10'd641);
        if (bl_d && !prev_bl_d) chk("blank_rise_drawx", x_d, 10'd1);
        prev_bl_d = bl_d;

        if (ls_d) begin
            if (last_ls_d >= 0) chk("line_period", t - last_ls_d, 1600);
            last_ls_d = t;
        end

        if (fs_s) begin
            if (last_fs_s >= 0) chk("frame_period_small", t - last_fs_s, 720);
            last_fs_s = t;
        end
        if (!vs_s && prev_vs_s) vs_low_s = 0;
        if (!vs_s) vs_low_s++;
        if (vs_s && !prev_vs_s) chk("vs_low_clks_small", vs_low_s, 144);
        prev_vs_s = vs_s;
        if (y_s != prev_y_s && prev_y_s == 10'd9) chk("drawy_wrap_small", y_s, 10'd0);
        prev_y_s = y_s;

        chk("fast_hs_window", hs_f, !((x_f >= 10'd656) && (x_f <= 10'd751)));
    endtask

    task automatic tick();
        @(posedge Clk);
        t++;
        push_all(1'b0);
        @(negedge Clk);
        compare_all();
        monitor();
    endtask

    initial begin
        bit found;
        monitor_init();

        repeat (2) @(negedge Clk);
        push_all(1'b1);
        #1 compare_all();

        @(negedge Clk);
        Reset_n = 1'b1;
        t = 0;
        push_all(1'b0);
        #1 compare_all();
        monitor();
        repeat (1700) tick();

        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            tick();
            if (x_s == 10'd10 && y_s == 10'd3) found = 1'b1;
        end
        chk("reach_reset_point", found, 1);

        // Asynchronous drop between clock edges; outputs must change without an edge
        #2 Reset_n = 1'b0;
        push_all(1'b1);
        #1 compare_all();
        repeat (3) begin
            @(negedge Clk);
            push_all(1'b1);
            #1 compare_all();
        end

        @(negedge Clk);
        Reset_n = 1'b1;
        t = 0;
        monitor_init();
        push_all(1'b0);
        #1 compare_all();
        monitor();
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
